morse_decode_module: RTL and testbench
======================================

// Module: morse_decode_module
// PURPOSE
//  Receive-side counterpart of the SOS generator: decodes on/off keyed Morse (key, photodiode or
//  looped-back LED/buzzer pin) into letters. Synchronises, debounces and times marks/spaces
//  against a unit period, classifies dot/dash, and emits one letter code per letter gap.
//  Flags a complete S-O-S sequence. Sits between a board input pin and display/LED logic.
// PARAMETERS
//  UNIT_CYC  5_000_000  clock cycles per Morse unit (100 ms at 50 MHz); >= 4
//  DB_CYC    500_000    consecutive equal samples required to accept a new level (10 ms); >= 1
// PORTS
//  CLK        input   1  system clock, all logic rising-edge
//  RST        input   1  asynchronous, active-high reset
//  Pin_In     input   1  raw keyed input, 1 = mark (tone/light on), asynchronous to CLK
//  Sym_Code   output  5  element bits of last letter, bit0 = first element, 1 = dash, unused bits 0
//  Sym_Len    output  3  number of elements in Sym_Code, 1..5
//  Sym_Valid  output  1  one-cycle strobe: Sym_Code/Sym_Len updated this cycle
//  SOS_Det    output  1  one-cycle strobe: letters S,O,S decoded consecutively within one word
//  Err        output  1  one-cycle strobe: malformed letter discarded
// BEHAVIOUR
//  Reset: all outputs 0; debounced level 0; element buffer empty; letter history cleared; FSM IDLE.
//  Sync/debounce: 2-FF synchroniser, then level accepted after DB_CYC consecutive equal samples.
//   Pin_In edge -> debounced edge in 2+DB_CYC cycles (fixed latency; all timing below from it).
//  Unit timer: prescaler 0..UNIT_CYC-1 and unit count (3-bit, saturates at 7); both cleared on
//   every debounced edge; unit count increments when prescaler wraps.
//  FSM states: IDLE (low, buffer empty), MARK (high), SPACE (low, buffer non-empty), DISCARD.
//   IDLE -rise-> MARK. MARK -fall-> classify: units<2 dot, 2..5 dash -> append, go SPACE;
//   units>=6 -> Err, clear buffer, go DISCARD. Append when buffer already holds 5 -> Err, DISCARD.
//   SPACE -rise-> MARK (intra-letter gap). SPACE, unit count reaches 3 -> Sym_Valid that cycle,
//   buffer cleared, go IDLE. IDLE low with unit count reaching 7 -> word end: history cleared.
//   DISCARD: ignores marks; leaves to IDLE after 3 units continuous low (no Sym_Valid).
//  Letter timing: Sym_Valid fires exactly 3*UNIT_CYC cycles after the last debounced fall,
//   not deferred to the next mark. Sym_Code/Sym_Len hold until next Sym_Valid.
//  SOS: 2-entry history of previous letters (S = len3 code 000, O = len3 code 111). SOS_Det
//   asserts in same cycle as Sym_Valid of an S when history is {S,O} (oldest first); history
//   then cleared so S-O-S-O-S yields one detection. Any other letter shifts into history.
//   Err clears history.
//  Simultaneous: debounced edge on same cycle the counter hits a threshold -> edge wins
//   (counter cleared, threshold event suppressed). Glitch shorter than DB_CYC: no effect.
//  Mid-operation RST: immediate clear, partial letter lost, no strobes; held key after release
//   is seen as a fresh rise after debounce.
// STRUCTURE
//  morse_defs.vh: UNIT thresholds (DASH_MIN=2, MARK_MAX=5, LETTER_GAP=3, WORD_GAP=7),
//   MAX_ELEM=5, S/O codes and lengths, FSM state encodings.
//  Sub-module debounce_module (sync + debounce, params DB_CYC, out level + rise/fall pulses).
//  Top holds unit timer, FSM, element shift buffer, history and strobes.
// TESTING (UNIT_CYC=8, DB_CYC=2)
//  1 key dot-dot-dot (1u on, 1u off), then 3u low -> Sym_Valid once, Sym_Code=00000, Sym_Len=3.
//  2 S,O,S letters (dash=3u), 3u letter gaps -> SOS_Det=1 with third Sym_Valid, O code 00111.
//  3 mark of 7u -> Err one cycle, no Sym_Valid until next clean letter; history cleared.
//  4 six dots in one letter -> Err on 6th fall, DISCARD, next letter decodes normally.
//  5 1-cycle glitches on Pin_In during SPACE -> no element appended, letter gap timing intact.
//  6 RST pulse mid-dash after S,O -> outputs 0, subsequent S gives Sym_Valid but no SOS_Det.

Source files
------------

// File: rtl/morse_decode_module_pkg.sv
// Shared definitions for the Morse receive path: unit thresholds, letter
// codes, FSM state encoding and small combinational helpers.
package morse_decode_module_pkg;

    // Timing thresholds, all in Morse units
    localparam logic [2:0] DASH_MIN   = 3'd2;  // marks of this many units or more are dashes
    localparam logic [2:0] MARK_MAX   = 3'd5;  // longest acceptable mark
    localparam logic [2:0] LETTER_GAP = 3'd3;  // low time that closes a letter
    localparam logic [2:0] WORD_GAP   = 3'd7;  // low time that closes a word
    localparam logic [2:0] MAX_ELEM   = 3'd5;  // element buffer depth

    // Letters recognised for the distress pattern (bit0 = first element, 1 = dash)
    localparam logic [4:0] S_CODE = 5'b00000;
    localparam logic [2:0] S_LEN  = 3'd3;
    localparam logic [4:0] O_CODE = 5'b00111;
    localparam logic [2:0] O_LEN  = 3'd3;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,  // line low, buffer empty
        ST_MARK    = 2'd1,  // line high, timing an element
        ST_SPACE   = 2'd2,  // line low, letter in progress
        ST_DISCARD = 2'd3   // malformed letter, waiting for a clean gap
    } state_t;

    typedef enum logic [1:0] {
        LET_NONE  = 2'd0,
        LET_S     = 2'd1,
        LET_O     = 2'd2,
        LET_OTHER = 2'd3
    } letter_t;

    // Reduce a decoded letter to the classes the history needs
    function automatic letter_t classify_letter(input logic [4:0] code, input logic [2:0] len);
        letter_t res;
        if ((len == S_LEN) && (code == S_CODE)) begin
            res = LET_S;
        end else if ((len == O_LEN) && (code == O_CODE)) begin
            res = LET_O;
        end else begin
            res = LET_OTHER;
        end
        return res;
    endfunction

    // Three-bit increment that sticks at its maximum
    function automatic logic [2:0] sat_inc3(input logic [2:0] v);
        logic [2:0] res;
        if (v == 3'd7) begin
            res = 3'd7;
        end else begin
            res = v + 3'd1;
        end
        return res;
    endfunction

    // Write one element bit into the buffer at position idx
    function automatic logic [4:0] append_elem(input logic [4:0] code, input logic [2:0] idx,
                                               input logic dash);
        logic [4:0] res;
        res = code;
        case (idx)
            3'd0:    res[0] = dash;
            3'd1:    res[1] = dash;
            3'd2:    res[2] = dash;
            3'd3:    res[3] = dash;
            3'd4:    res[4] = dash;
            default: res = code;
        endcase
        return res;
    endfunction

endpackage

// File: rtl/morse_decode_module_debounce.sv
// Two-flop synchroniser followed by a level debouncer. A new level is taken
// after DB_CYC consecutive samples that differ from the current one; the
// rise/fall pulses are high in the first cycle of the new level.
module debounce_module
    import morse_decode_module_pkg::*;
#(
    parameter int DB_CYC = 500_000
) (
    input  logic clk,
    input  logic rst,
    input  logic pin_async,
    output logic level,
    output logic rise,
    output logic fall
);

    localparam int CNT_W = (DB_CYC > 1) ? $clog2(DB_CYC) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DB_CYC - 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(32'd1);
    localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};

    logic             sync1_r;
    logic             sync2_r;
    logic             level_r;
    logic             rise_r;
    logic             fall_r;
    logic [CNT_W-1:0] cnt_r;

    // Bring the asynchronous pin into the clock domain
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync1_r <= 1'b0;
            sync2_r <= 1'b0;
        end else begin
            sync1_r <= pin_async;
            sync2_r <= sync1_r;
        end
    end

    // Count consecutive differing samples and accept the level when stable
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            level_r <= 1'b0;
            rise_r  <= 1'b0;
            fall_r  <= 1'b0;
            cnt_r   <= CNT_ZERO;
        end else begin
            rise_r <= 1'b0;
            fall_r <= 1'b0;
            if (sync2_r != level_r) begin
                if (cnt_r == CNT_LAST) begin
                    level_r <= sync2_r;
                    rise_r  <= sync2_r;
                    fall_r  <= ~sync2_r;
                    cnt_r   <= CNT_ZERO;
                end else begin
                    cnt_r <= cnt_r + CNT_ONE;
                end
            end else begin
                cnt_r <= CNT_ZERO;
            end
        end
    end

    assign level = level_r;
    assign rise  = rise_r;
    assign fall  = fall_r;

endmodule

// File: rtl/morse_decode_module.sv
// Morse receiver: debounced key input is timed in Morse units, marks are
// classified into dots and dashes, letters are emitted after a letter gap,
// and an S-O-S sequence within one word is flagged.
module morse_decode_module
    import morse_decode_module_pkg::*;
#(
    parameter int UNIT_CYC = 5_000_000,
    parameter int DB_CYC   = 500_000
) (
    input  logic       CLK,
    input  logic       RST,
    input  logic       Pin_In,
    output logic [4:0] Sym_Code,
    output logic [2:0] Sym_Len,
    output logic       Sym_Valid,
    output logic       SOS_Det,
    output logic       Err
);

    localparam int PRE_W = $clog2(UNIT_CYC);
    localparam logic [PRE_W-1:0] PRE_LAST = PRE_W'(UNIT_CYC - 1);
    localparam logic [PRE_W-1:0] PRE_ONE  = PRE_W'(32'd1);
    localparam logic [PRE_W-1:0] PRE_ZERO = {PRE_W{1'b0}};

    logic             level_s;
    logic             rise_s;
    logic             fall_s;

    logic [PRE_W-1:0] pre_r;
    logic [2:0]       units_r;
    logic             edge_s;
    logic [PRE_W-1:0] pre_cur_s;
    logic [2:0]       units_cur_s;
    logic             tick_s;

    state_t           state_r;
    state_t           state_nxt_s;
    logic [4:0]       code_r;
    logic [4:0]       code_nxt_s;
    logic [2:0]       cnt_r;
    logic [2:0]       cnt_nxt_s;
    logic             emit_s;
    logic             err_s;
    logic             word_end_s;

    letter_t          letter_s;
    letter_t          hist_old_r;
    letter_t          hist_new_r;
    letter_t          hist_old_nxt_s;
    letter_t          hist_new_nxt_s;
    logic             sos_s;

    logic [4:0]       sym_code_r;
    logic [2:0]       sym_len_r;
    logic             sym_valid_r;
    logic             sos_det_r;
    logic             err_r;

    debounce_module #(
        .DB_CYC(DB_CYC)
    ) u_debounce (
        .clk      (CLK),
        .rst      (RST),
        .pin_async(Pin_In),
        .level    (level_s),
        .rise     (rise_s),
        .fall     (fall_s)
    );

    // Timer view of this cycle: an edge restarts counting from this very cycle,
    // so a threshold can never coincide with an edge
    always_comb begin
        edge_s = rise_s | fall_s;
        if (edge_s) begin
            pre_cur_s   = PRE_ZERO;
            units_cur_s = 3'd0;
        end else begin
            pre_cur_s   = pre_r;
            units_cur_s = units_r;
        end
        tick_s = (pre_cur_s == PRE_LAST);
    end

    // Unit prescaler and saturating unit count
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            pre_r   <= PRE_ZERO;
            units_r <= 3'd0;
        end else if (tick_s) begin
            pre_r   <= PRE_ZERO;
            units_r <= sat_inc3(units_cur_s);
        end else begin
            pre_r   <= pre_cur_s + PRE_ONE;
            units_r <= units_cur_s;
        end
    end

    // Letter FSM: next state, element buffer update and event detection
    always_comb begin
        state_nxt_s = state_r;
        code_nxt_s  = code_r;
        cnt_nxt_s   = cnt_r;
        emit_s      = 1'b0;
        err_s       = 1'b0;
        word_end_s  = 1'b0;
        case (state_r)
            ST_IDLE: begin
                if (rise_s) begin
                    state_nxt_s = ST_MARK;
                end else if (tick_s && (units_cur_s == (WORD_GAP - 3'd1))) begin
                    word_end_s = 1'b1;
                end else begin
                    state_nxt_s = ST_IDLE;
                end
            end
            ST_MARK: begin
                if (fall_s) begin
                    // units_r holds the full mark length in whole units here
                    if ((units_r > MARK_MAX) || (cnt_r == MAX_ELEM)) begin
                        err_s       = 1'b1;
                        code_nxt_s  = 5'b00000;
                        cnt_nxt_s   = 3'd0;
                        state_nxt_s = ST_DISCARD;
                    end else begin
                        code_nxt_s  = append_elem(code_r, cnt_r, (units_r >= DASH_MIN));
                        cnt_nxt_s   = cnt_r + 3'd1;
                        state_nxt_s = ST_SPACE;
                    end
                end else begin
                    state_nxt_s = ST_MARK;
                end
            end
            ST_SPACE: begin
                if (rise_s) begin
                    state_nxt_s = ST_MARK;
                end else if (tick_s && (units_cur_s == (LETTER_GAP - 3'd1))) begin
                    emit_s      = 1'b1;
                    code_nxt_s  = 5'b00000;
                    cnt_nxt_s   = 3'd0;
                    state_nxt_s = ST_IDLE;
                end else begin
                    state_nxt_s = ST_SPACE;
                end
            end
            ST_DISCARD: begin
                if (!level_s && tick_s && (units_cur_s == (LETTER_GAP - 3'd1))) begin
                    state_nxt_s = ST_IDLE;
                end else begin
                    state_nxt_s = ST_DISCARD;
                end
            end
            default: begin
                state_nxt_s = ST_IDLE;
                code_nxt_s  = 5'b00000;
                cnt_nxt_s   = 3'd0;
            end
        endcase
    end

    // FSM state and element buffer registers
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state_r <= ST_IDLE;
            code_r  <= 5'b00000;
            cnt_r   <= 3'd0;
        end else begin
            state_r <= state_nxt_s;
            code_r  <= code_nxt_s;
            cnt_r   <= cnt_nxt_s;
        end
    end

    // Letter history: detect S after {S,O}, otherwise shift in the new letter
    always_comb begin
        letter_s       = classify_letter(code_r, cnt_r);
        sos_s          = emit_s && (letter_s == LET_S) &&
                         (hist_old_r == LET_S) && (hist_new_r == LET_O);
        hist_old_nxt_s = hist_old_r;
        hist_new_nxt_s = hist_new_r;
        if (err_s || word_end_s || sos_s) begin
            hist_old_nxt_s = LET_NONE;
            hist_new_nxt_s = LET_NONE;
        end else if (emit_s) begin
            hist_old_nxt_s = hist_new_r;
            hist_new_nxt_s = letter_s;
        end else begin
            hist_old_nxt_s = hist_old_r;
            hist_new_nxt_s = hist_new_r;
        end
    end

    // History registers
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            hist_old_r <= LET_NONE;
            hist_new_r <= LET_NONE;
        end else begin
            hist_old_r <= hist_old_nxt_s;
            hist_new_r <= hist_new_nxt_s;
        end
    end

    // Registered outputs: strobes for one cycle, letter fields held between letters
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            sym_code_r  <= 5'b00000;
            sym_len_r   <= 3'd0;
            sym_valid_r <= 1'b0;
            sos_det_r   <= 1'b0;
            err_r       <= 1'b0;
        end else begin
            sym_valid_r <= emit_s;
            sos_det_r   <= sos_s;
            err_r       <= err_s;
            if (emit_s) begin
                sym_code_r <= code_r;
                sym_len_r  <= cnt_r;
            end else begin
                sym_code_r <= sym_code_r;
                sym_len_r  <= sym_len_r;
            end
        end
    end

    assign Sym_Code  = sym_code_r;
    assign Sym_Len   = sym_len_r;
    assign Sym_Valid = sym_valid_r;
    assign SOS_Det   = sos_det_r;
    assign Err       = err_r;

endmodule

// File: tb/tb_morse_decode_module.sv
// Directed bench for the Morse receiver with a short unit (8 cycles) and
// debounce (2 cycles). Single letters come from a vector table; timing,
// glitch, word-gap and reset scenarios are written out by hand.
module tb_morse_decode_module;

    localparam int UNIT    = 8;
    localparam int DB      = 2;
    localparam int LATENCY = 2 + DB + 3 * UNIT;  // pin fall -> Sym_Valid sample cycle

    logic       clk;
    logic       rst;
    logic       pin_in;
    logic [4:0] sym_code;
    logic [2:0] sym_len;
    logic       sym_valid;
    logic       sos_det;
    logic       err;

    int n_cmp;
    int n_bad;
    int cyc;
    int valid_cnt;
    int sos_cnt;
    int err_cnt;
    int valid_cyc;
    int sos_cyc;
    logic [7:0] codes_seen [8];

    typedef struct packed {
        logic [2:0]  n;          // number of marks
        logic [17:0] dur;        // mark lengths in units, octal digit i = element i
        logic [1:0]  exp_valid;  // Sym_Valid strobes expected
        logic [1:0]  exp_err;    // Err strobes expected
        logic [2:0]  exp_len;    // Sym_Len afterwards (held if no letter)
        logic [4:0]  exp_code;   // Sym_Code afterwards (held if no letter)
    } vec_t;

    localparam int NV = 11;
    vec_t vecs [NV];

    morse_decode_module #(
        .UNIT_CYC(UNIT),
        .DB_CYC  (DB)
    ) dut (
        .CLK      (clk),
        .RST      (rst),
        .Pin_In   (pin_in),
        .Sym_Code (sym_code),
        .Sym_Len  (sym_len),
        .Sym_Valid(sym_valid),
        .SOS_Det  (sos_det),
        .Err      (err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Strobe monitor, sampled on the falling edge
    always @(negedge clk) begin
        if (rst === 1'b0) begin
            if (sym_valid === 1'b1) begin
                if (valid_cnt < 8) codes_seen[valid_cnt] = {sym_len, sym_code};
                valid_cnt = valid_cnt + 1;
                valid_cyc = cyc;
            end
            if (sos_det === 1'b1) begin
                sos_cnt = sos_cnt + 1;
                sos_cyc = cyc;
            end
            if (err === 1'b1) err_cnt = err_cnt + 1;
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp = n_cmp + 1;
        if (act !== exp) begin
            n_bad = n_bad + 1;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic mark_u(input int u);
        pin_in = 1'b1;
        tick(u * UNIT);
        pin_in = 1'b0;
    endtask

    task automatic space_u(input int u);
        pin_in = 1'b0;
        tick(u * UNIT);
    endtask

    task automatic send_letter(input logic [2:0] n, input logic [17:0] dur);
        for (int e = 0; e < int'(n); e++) begin
            if (e > 0) space_u(1);
            mark_u(int'(dur[3*e +: 3]));
        end
    endtask

    task automatic clear_mon();
        valid_cnt = 0;
        sos_cnt   = 0;
        err_cnt   = 0;
        valid_cyc = -1;
        sos_cyc   = -2;
        for (int i = 0; i < 8; i++) codes_seen[i] = 8'h00;
    endtask

    task automatic check_idle_outputs(input string tag);
        check({tag, "_code"},  32'(sym_code),  32'd0);
        check({tag, "_len"},   32'(sym_len),   32'd0);
        check({tag, "_valid"}, 32'(sym_valid), 32'd0);
        check({tag, "_sos"},   32'(sos_det),   32'd0);
        check({tag, "_err"},   32'(err),       32'd0);
    endtask

    localparam logic [2:0]  N3   = 3'd3;
    localparam logic [17:0] D_S  = 18'o000111;
    localparam logic [17:0] D_O  = 18'o000333;

    initial begin
        int k;
        n_cmp  = 0;
        n_bad  = 0;
        cyc    = 0;
        pin_in = 1'b0;
        rst    = 1'b1;
        clear_mon();

        //           n     dur          valid  err    len    code
        vecs[0]  = '{3'd3, 18'o000111, 2'd1, 2'd0, 3'd3, 5'b00000};  // S
        vecs[1]  = '{3'd3, 18'o000333, 2'd1, 2'd0, 3'd3, 5'b00111};  // O
        vecs[2]  = '{3'd2, 18'o000031, 2'd1, 2'd0, 3'd2, 5'b00010};  // A
        vecs[3]  = '{3'd1, 18'o000002, 2'd1, 2'd0, 3'd1, 5'b00001};  // 2u mark is a dash
        vecs[4]  = '{3'd1, 18'o000005, 2'd1, 2'd0, 3'd1, 5'b00001};  // 5u longest dash
        vecs[5]  = '{3'd1, 18'o000006, 2'd0, 2'd1, 3'd1, 5'b00001};  // 6u mark: error, hold
        vecs[6]  = '{3'd5, 18'o031313, 2'd1, 2'd0, 3'd5, 5'b10101};  // five elements
        vecs[7]  = '{3'd6, 18'o111111, 2'd0, 2'd1, 3'd5, 5'b10101};  // six dots: error
        vecs[8]  = '{3'd1, 18'o000007, 2'd0, 2'd1, 3'd5, 5'b10101};  // 7u mark: error
        vecs[9]  = '{3'd1, 18'o000001, 2'd1, 2'd0, 3'd1, 5'b00000};  // E after discard
        vecs[10] = '{3'd3, 18'o000113, 2'd1, 2'd0, 3'd3, 5'b00001};  // D

        // Reset state
        tick(4);
        check_idle_outputs("reset");
        rst = 1'b0;
        tick(2 * UNIT);

        // Table of single letters, each followed by a 4-unit gap
        for (int i = 0; i < NV; i++) begin
            clear_mon();
            send_letter(vecs[i].n, vecs[i].dur);
            space_u(4);
            check($sformatf("vec%0d_valid", i), 32'(valid_cnt), 32'(vecs[i].exp_valid));
            check($sformatf("vec%0d_err", i),   32'(err_cnt),   32'(vecs[i].exp_err));
            check($sformatf("vec%0d_sos", i),   32'(sos_cnt),   32'd0);
            check($sformatf("vec%0d_code", i),  32'(sym_code),  32'(vecs[i].exp_code));
            check($sformatf("vec%0d_len", i),   32'(sym_len),   32'(vecs[i].exp_len));
        end
        space_u(8);

        // S, O, S with exact 3-unit letter gaps; detection and letter timing
        clear_mon();
        send_letter(N3, D_S);
        space_u(3);
        send_letter(N3, D_O);
        space_u(3);
        send_letter(N3, D_S);
        k = cyc;
        space_u(8);
        check("sos_valid_cnt", 32'(valid_cnt), 32'd3);
        check("sos_det_cnt",   32'(sos_cnt),   32'd1);
        check("sos_o_code",    32'(codes_seen[1]), 32'({3'd3, 5'b00111}));
        check("sos_s_code",    32'(codes_seen[2]), 32'({3'd3, 5'b00000}));
        check("sos_timing",    32'(valid_cyc), 32'(k + LATENCY));
        check("sos_same_cyc",  32'(sos_cyc),   32'(valid_cyc));

        // Over-long mark between O and S clears the history
        clear_mon();
        send_letter(N3, D_S);
        space_u(3);
        send_letter(N3, D_O);
        space_u(3);
        mark_u(7);
        space_u(4);
        send_letter(N3, D_S);
        space_u(8);
        check("longmark_valid", 32'(valid_cnt), 32'd3);
        check("longmark_err",   32'(err_cnt),   32'd1);
        check("longmark_sos",   32'(sos_cnt),   32'd0);

        // One-cycle glitches in intra-letter and letter gaps are ignored
        clear_mon();
        mark_u(1);
        tick(3); pin_in = 1'b1; tick(1); pin_in = 1'b0; tick(4);
        mark_u(1);
        tick(3); pin_in = 1'b1; tick(1); pin_in = 1'b0; tick(4);
        mark_u(1);
        k = cyc;
        tick(5); pin_in = 1'b1; tick(1); pin_in = 1'b0;
        tick(14); pin_in = 1'b1; tick(1); pin_in = 1'b0;
        tick(43);
        check("glitch_valid",  32'(valid_cnt), 32'd1);
        check("glitch_err",    32'(err_cnt),   32'd0);
        check("glitch_letter", 32'(codes_seen[0]), 32'({3'd3, 5'b00000}));
        check("glitch_timing", 32'(valid_cyc), 32'(k + LATENCY));

        // S-O-S-O-S gives a single detection
        clear_mon();
        for (int i = 0; i < 5; i++) begin
            if (i > 0) space_u(3);
            if ((i % 2) == 0) send_letter(N3, D_S);
            else              send_letter(N3, D_O);
        end
        space_u(8);
        check("sosos_valid", 32'(valid_cnt), 32'd5);
        check("sosos_det",   32'(sos_cnt),   32'd1);

        // A word gap between O and S prevents detection
        clear_mon();
        send_letter(N3, D_S);
        space_u(3);
        send_letter(N3, D_O);
        space_u(8);
        send_letter(N3, D_S);
        space_u(8);
        check("wordgap_valid", 32'(valid_cnt), 32'd3);
        check("wordgap_sos",   32'(sos_cnt),   32'd0);

        // Reset in the middle of a dash after S,O; held key is a fresh mark
        send_letter(N3, D_S);
        space_u(3);
        send_letter(N3, D_O);
        space_u(3);
        pin_in = 1'b1;
        tick(UNIT + UNIT / 2);
        rst = 1'b1;
        tick(2);
        check_idle_outputs("midrst");
        clear_mon();
        rst = 1'b0;
        tick(3 * UNIT);
        pin_in = 1'b0;
        space_u(3);
        send_letter(N3, D_S);
        space_u(8);
        check("midrst_valid",  32'(valid_cnt), 32'd2);
        check("midrst_sos",    32'(sos_cnt),   32'd0);
        check("midrst_first",  32'(codes_seen[0]), 32'({3'd1, 5'b00001}));
        check("midrst_second", 32'(codes_seen[1]), 32'({3'd3, 5'b00000}));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
